// File: rtl/display_scan_driver_if.sv
// Bus between the display scan driver and its client: load request, captured
// value and mode, and the digit outputs fed to the seven segment controller.
interface display_scan_driver_if;
  logic [7:0] value;
  logic       decimalMode;
  logic       load;
  logic       counter;
  logic [3:0] segment2;
  logic [3:0] segment1;
  logic       busy;
  logic       overflow;

  // Client side: issues loads and watches the display outputs.
  modport master (
    output value, decimalMode, load,
    input  counter, segment2, segment1, busy, overflow
  );

  // Driver side.
  modport slave (
    input  value, decimalMode, load,
    output counter, segment2, segment1, busy, overflow
  );
endinterface

// File: rtl/display_scan_driver.sv
// Display scan driver: captures an 8-bit value on load, optionally converts it to
// BCD (double dabble, one bit per cycle), and presents two digit nibbles plus a
// free-running digit-select toggle for multiplexing the display.
module display_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic                 clock,
  input logic                 reset,
  display_scan_driver_if.slave bus
);

  localparam int unsigned PrescW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

  state_e            state_q, state_d;
  logic [PrescW-1:0] presc_q;
  logic              counter_q;
  logic [7:0]        bin_q, bin_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [11:0]       bcd_adj;
  logic [2:0]        iter_q, iter_d;
  logic              dec_q, dec_d;
  logic [3:0]        seg2_q, seg2_d;
  logic [3:0]        seg1_q, seg1_d;
  logic              ovf_q, ovf_d;

  // Refresh prescaler and digit select; free-running, unaffected by the FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q   <= '0;
      counter_q <= 1'b0;
    end else if (presc_q == PrescW'(REFRESH_DIV - 1)) begin
      presc_q   <= '0;
      counter_q <= ~counter_q;
    end else begin
      presc_q   <= presc_q + PrescW'(1);
    end
  end

  // FSM state and conversion/output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      dec_q   <= 1'b0;
      seg2_q  <= '0;
      seg1_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      iter_q  <= iter_d;
      dec_q   <= dec_d;
      seg2_q  <= seg2_d;
      seg1_q  <= seg1_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: capture in idle, one double-dabble step per convert
  // cycle, publish outputs on the cycle leaving update.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    dec_d   = dec_q;
    seg2_d  = seg2_q;
    seg1_d  = seg1_q;
    ovf_d   = ovf_q;

    // Add 3 to every BCD digit >= 5 ahead of the shift.
    bcd_adj = bcd_q;
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (bus.load) begin
          bin_d   = bus.value;
          dec_d   = bus.decimalMode;
          bcd_d   = '0;
          iter_d  = '0;
          state_d = bus.decimalMode ? StConvert : StUpdate;
        end
      end
      StConvert: begin
        bcd_d  = {bcd_adj[10:0], bin_q[7]};
        bin_d  = {bin_q[6:0], 1'b0};
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = StUpdate;
        end
      end
      StUpdate: begin
        if (dec_q) begin
          seg2_d = bcd_q[7:4];
          seg1_d = bcd_q[3:0];
          ovf_d  = (bcd_q[11:8] != 4'd0);
        end else begin
          seg2_d = bin_q[7:4];
          seg1_d = bin_q[3:0];
          ovf_d  = 1'b0;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.counter  = counter_q;
  assign bus.segment2 = seg2_q;
  assign bus.segment1 = seg1_q;
  assign bus.overflow = ovf_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_display_scan_driver.sv
// Directed bench for display_scan_driver with a short refresh divider.
module tb_display_scan_driver;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  display_scan_driver_if dif ();

  display_scan_driver #(
    .REFRESH_DIV(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (dif)
  );

  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check both digits and the overflow flag together.
  task automatic check_out(input string tag, input logic [3:0] s2, input logic [3:0] s1,
                           input logic ov);
    check({tag, ".seg2"}, 32'(dif.segment2), 32'(s2));
    check({tag, ".seg1"}, 32'(dif.segment1), 32'(s1));
    check({tag, ".ovf"},  32'(dif.overflow), 32'(ov));
  endtask

  initial begin
    dif.value       = 8'h77;
    dif.decimalMode = 1'b0;
    dif.load        = 1'b1;   // load during reset must be ignored

    // Reset, then release and check reset state.
    step();
    step();
    reset    = 1'b0;
    dif.load = 1'b0;
    check("rst.busy", 32'(dif.busy), 32'd0);
    check("rst.cnt", 32'(dif.counter), 32'd0);
    check_out("rst", 4'h0, 4'h0, 1'b0);

    // Refresh: counter toggles every 4 cycles while loads come and go.
    dif.value = 8'h00;
    for (int k = 0; k < 12; k++) begin
      check($sformatf("refresh.k%0d", k), 32'(dif.counter), 32'((k / 4) % 2));
      dif.load = (k % 2 == 1);
      step();
    end
    dif.load = 1'b0;
    step();
    check("refresh.idle", 32'(dif.busy), 32'd0);

    // Hex load of 0xA5: busy one cycle, outputs at E1.
    dif.value       = 8'hA5;
    dif.decimalMode = 1'b0;
    dif.load        = 1'b1;
    step();  // E0
    dif.load  = 1'b0;
    dif.value = 8'h3C;  // must not matter after capture
    check("hex.busyE0", 32'(dif.busy), 32'd1);
    check_out("hex.E0", 4'h0, 4'h0, 1'b0);
    step();  // E1
    check("hex.busyE1", 32'(dif.busy), 32'd0);
    check_out("hex.E1", 4'hA, 4'h5, 1'b0);
    step();
    check_out("hex.hold", 4'hA, 4'h5, 1'b0);

    // Decimal load of 63: busy E0..E8, outputs only at E9.
    dif.value       = 8'd63;
    dif.decimalMode = 1'b1;
    dif.load        = 1'b1;
    step();  // E0
    dif.load        = 1'b0;
    dif.value       = 8'd0;
    dif.decimalMode = 1'b0;
    check("dec63.busyE0", 32'(dif.busy), 32'd1);
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("dec63.busyE%0d", e), 32'(dif.busy), 32'd1);
      check($sformatf("dec63.segE%0d", e), 32'({dif.segment2, dif.segment1}), 32'h00A5);
    end
    step();  // E9
    check("dec63.busyE9", 32'(dif.busy), 32'd0);
    check_out("dec63.E9", 4'd6, 4'd3, 1'b0);

    // Decimal 255: shows 55 with overflow.
    dif.value       = 8'd255;
    dif.decimalMode = 1'b1;
    dif.load        = 1'b1;
    step();
    dif.load = 1'b0;
    for (int e = 1; e <= 9; e++) step();
    check_out("dec255", 4'd5, 4'd5, 1'b1);

    // Decimal 99 clears overflow; a load on the return edge E9 is dropped.
    dif.value = 8'd99;
    dif.load  = 1'b1;
    step();
    dif.load = 1'b0;
    for (int e = 1; e <= 8; e++) step();
    dif.value       = 8'h11;
    dif.decimalMode = 1'b0;
    dif.load        = 1'b1;
    step();  // E9
    dif.load = 1'b0;
    check("dec99.busyE9", 32'(dif.busy), 32'd0);
    check_out("dec99", 4'd9, 4'd9, 1'b0);
    step();
    check("retload.busy", 32'(dif.busy), 32'd0);
    check_out("retload", 4'd9, 4'd9, 1'b0);

    // Busy ignore: decimal 12, hex 0xFF attempted at E3.
    dif.value       = 8'd12;
    dif.decimalMode = 1'b1;
    dif.load        = 1'b1;
    step();  // E0
    dif.load = 1'b0;
    step();  // E1
    step();  // E2
    dif.value       = 8'hFF;
    dif.decimalMode = 1'b0;
    dif.load        = 1'b1;
    step();  // E3
    dif.load = 1'b0;
    check("ign.busyE3", 32'(dif.busy), 32'd1);
    for (int e = 4; e <= 8; e++) step();
    check("ign.busyE8", 32'(dif.busy), 32'd1);
    step();  // E9
    check("ign.busyE9", 32'(dif.busy), 32'd0);
    check_out("ign.E9", 4'd1, 4'd2, 1'b0);
    for (int e = 0; e < 3; e++) begin
      step();
      check($sformatf("ign.nopulse%0d", e), 32'(dif.busy), 32'd0);
    end
    check_out("ign.hold", 4'd1, 4'd2, 1'b0);

    // Reset mid-conversion: decimal 200, reset at E4 clears everything.
    dif.value       = 8'd200;
    dif.decimalMode = 1'b1;
    dif.load        = 1'b1;
    step();  // E0
    dif.load = 1'b0;
    step();  // E1
    step();  // E2
    step();  // E3
    reset    = 1'b1;
    dif.load = 1'b1;  // ignored under reset
    step();  // E4
    reset    = 1'b0;
    dif.load = 1'b0;
    check("rstmid.busy", 32'(dif.busy), 32'd0);
    check("rstmid.cnt", 32'(dif.counter), 32'd0);
    check_out("rstmid.E4", 4'd0, 4'd0, 1'b0);
    for (int e = 5; e <= 10; e++) step();
    check("rstmid.busyE10", 32'(dif.busy), 32'd0);
    check_out("rstmid.E10", 4'd0, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles per displayed digit (legal range 2..2^20).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port value  input  8  binary value to display; sampled only on an accepted load.
REQ-005 SHALL have port decimalMode  input  1  1 = decimal display (00..99), 0 = hex display (00..FF); sampled with value.
REQ-006 SHALL have port load  input  1  single-cycle request to capture value/decimalMode.
REQ-007 SHALL have port counter  output  1  digit select to the seven segment controller; 0 = segment1 digit, 1 = segment2 digit.
REQ-008 SHALL have port segment2  output  4  upper digit nibble (hex high nibble or decimal tens).
REQ-009 SHALL have port segment1  output  4  lower digit nibble (hex low nibble or decimal ones).
REQ-010 SHALL have port busy  output  1  high while a capture/conversion is in progress.
REQ-011 SHALL have port overflow  output  1  high when the last decimal value exceeded 99.

Function
REQ-012 Refresh prescaler SHALL count 0..REFRESH_DIV-1 and wrap to 0; counter SHALL toggle on the edge where the prescaler wraps.
REQ-013 Prescaler and counter SHALL run continuously, independent of load, busy and FSM state.
REQ-014 FSM SHALL have states IDLE, CONVERT, UPDATE; busy SHALL equal (state != IDLE), decoded from registered state.
REQ-015 In IDLE with load=1 at edge E0, SHALL capture value and decimalMode; next state CONVERT if decimalMode=1, else UPDATE.
REQ-016 load SHALL be ignored whenever state != IDLE; no queuing.
REQ-017 CONVERT SHALL perform 8 double-dabble iterations, one per edge E1..E8: add 3 to each BCD digit >= 5, then shift left one bit, MSB of the binary register entering BCD bit 0.
REQ-018 BCD register SHALL be 12 bits (hundreds, tens, ones); iteration counter 3 bits; transition CONVERT->UPDATE on edge E8.
REQ-019 On the edge leaving UPDATE (E1 hex, E9 decimal) SHALL write outputs and return to IDLE.
REQ-020 Hex update SHALL set segment2=value[7:4], segment1=value[3:0], overflow=0.
REQ-021 Decimal update SHALL set segment2=tens, segment1=ones, overflow=(hundreds != 0); i.e. value mod 100 is shown.
REQ-022 segment2, segment1, overflow SHALL hold their values between updates; changes to value/decimalMode outside an accepted load SHALL have no effect.
REQ-023 busy SHALL be high for exactly 1 cycle (hex) or 9 cycles (decimal) per accepted load.
REQ-024 load asserted on the same edge the FSM returns to IDLE SHALL be ignored; load is accepted only when sampled with state=IDLE.

Reset
REQ-025 reset=1 at a rising edge SHALL set prescaler=0, counter=0, state=IDLE, segment2=0, segment1=0, overflow=0, busy=0.
REQ-026 reset SHALL take priority over load and over any in-progress conversion; an aborted conversion SHALL leave no output update.
REQ-027 load sampled with reset=1 SHALL be ignored.

Verification
REQ-028 Hex: decimalMode=0, value=0xA5, load at E0 -> busy high one cycle, at E1 segment2=4'hA, segment1=4'h5, overflow=0.
REQ-029 Decimal: decimalMode=1, value=63, load at E0 -> busy high E0..E9, at E9 segment2=6, segment1=3, overflow=0; outputs unchanged before E9.
REQ-030 Overflow: decimalMode=1, value=255 -> at E9 segment2=5, segment1=5, overflow=1; then value=99 -> 9, 9, overflow=0.
REQ-031 Refresh: REFRESH_DIV=4, reset released -> counter toggles every 4 cycles (0,0,0,0,1,1,1,1,0...) regardless of load activity.
REQ-032 Busy ignore: decimal load of 12, second load of 0xFF (hex) at E3 -> final outputs 1, 2; busy falls after E9; no second busy pulse.
REQ-033 Reset mid-op: decimal load of 200, reset at E4 -> all outputs 0, busy=0 at E4; segments remain 0 with no update at E9.
